// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: one CHUNK-bit slice resolved per stage, carry rippled stage to
// stage, with skew/deskew registers and a valid/ready handshake that stalls the whole pipe.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             VALID_i,
    output logic             READY_o,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             C_i,
    input  logic             SUB_i,
    output logic             VALID_o,
    input  logic             READY_i,
    output logic [WIDTH-1:0] S_o,
    output logic             C_o,
    output logic             V_o
);
    localparam int Width    = int'(WIDTH);
    localparam int Stages   = int'(STAGES);
    localparam int Chunk    = Width / Stages;
    // Deskew storage is triangular: stage k holds the (k+1) finished low slices.
    localparam int SumBits  = Chunk * Stages * (Stages + 1) / 2;
    // Skew storage is triangular too: stage k holds the Width-(k+1)*Chunk unprocessed bits.
    localparam int SkewRaw  = (Stages - 1) * Width - Chunk * (Stages - 1) * Stages / 2;
    localparam int SkewBits = (SkewRaw > 0) ? SkewRaw : 1;

    logic [STAGES-1:0]   vld_q, vld_d;
    logic [STAGES-1:0]   cy_q, cy_d;
    logic [SumBits-1:0]  sum_q, sum_d;
    logic [SkewBits-1:0] a_skew_q, a_skew_d;
    logic [SkewBits-1:0] b_skew_q, b_skew_d;
    logic                ovf_q, ovf_d;
    logic                adv;

    assign adv = ~vld_q[STAGES-1] | READY_i;

    for (genvar k = 0; k < Stages; k++) begin : g_stage
        localparam int Rem    = Width - k * Chunk;
        localparam int SumLo  = Chunk * k * (k + 1) / 2;
        localparam int SkewLo = k * Width - Chunk * k * (k + 1) / 2;

        logic [Rem-1:0] a_in;
        logic [Rem-1:0] b_in;
        logic           c_in;
        logic [Chunk:0] slice;

        if (k == 0) begin : g_entry
            assign a_in             = A_i;
            assign b_in             = SUB_i ? ~B_i : B_i;
            assign c_in             = SUB_i ^ C_i;
            assign vld_d[k]         = VALID_i;
            assign sum_d[Chunk-1:0] = slice[Chunk-1:0];
        end else begin : g_link
            localparam int PrevSkewLo = (k - 1) * Width - Chunk * (k - 1) * k / 2;
            assign a_in     = a_skew_q[PrevSkewLo +: Rem];
            assign b_in     = b_skew_q[PrevSkewLo +: Rem];
            assign c_in     = cy_q[k-1];
            assign vld_d[k] = vld_q[k-1];
            assign sum_d[SumLo +: (k + 1) * Chunk] =
                {slice[Chunk-1:0], sum_q[SumLo - k * Chunk +: k * Chunk]};
        end

        assign slice   = {1'b0, a_in[Chunk-1:0]} + {1'b0, b_in[Chunk-1:0]}
                       + {{Chunk{1'b0}}, c_in};
        assign cy_d[k] = slice[Chunk];

        if (k < Stages - 1) begin : g_skew
            assign a_skew_d[SkewLo +: Rem - Chunk] = a_in[Rem-1:Chunk];
            assign b_skew_d[SkewLo +: Rem - Chunk] = b_in[Rem-1:Chunk];
        end else begin : g_last
            // Top slice holds the sign bits of A and B_eff.
            assign ovf_d = (a_in[Chunk-1] == b_in[Chunk-1]) & (slice[Chunk-1] != a_in[Chunk-1]);
        end
    end

    if (SkewRaw == 0) begin : g_no_skew
        assign a_skew_d = '0;
        assign b_skew_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q    <= '0;
            cy_q     <= '0;
            sum_q    <= '0;
            a_skew_q <= '0;
            b_skew_q <= '0;
            ovf_q    <= 1'b0;
        end else if (adv) begin
            vld_q    <= vld_d;
            cy_q     <= cy_d;
            sum_q    <= sum_d;
            a_skew_q <= a_skew_d;
            b_skew_q <= b_skew_d;
            ovf_q    <= ovf_d;
        end
    end

    // Result fields are masked so bubbles never show stale data.
    assign READY_o = adv;
    assign VALID_o = vld_q[STAGES-1];
    assign S_o     = VALID_o ? sum_q[SumBits-1 -: WIDTH] : '0;
    assign C_o     = VALID_o & cy_q[STAGES-1];
    assign V_o     = VALID_o & ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed vectors, random streaming against an
// arithmetic reference model, back-pressure, mid-flight reset and a parameter sweep.
module tb_pipelined_adder;
    localparam int unsigned W   = 32;
    localparam int unsigned L   = 4;
    localparam int          SwN = 60;

    typedef struct packed {
        logic        v;
        logic        c;
        logic [63:0] s;
    } res_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         valid_in, ready_out, valid_out, ready_in;
    logic         c_in, sub_in, c_out, v_out;
    logic [W-1:0] a_in, b_in, s_out;
    int           checks = 0;
    int           errors = 0;

    // Sweep instances share one stimulus stream, truncated to their width.
    logic        sw_valid, sw_ready, sw_c, sw_sub;
    logic [63:0] sw_a, sw_b;
    logic [63:0] sw_ah [SwN];
    logic [63:0] sw_bh [SwN];
    logic        sw_ch [SwN];
    logic        sw_subh [SwN];
    logic        r1_rdy, r1_vld, r1_c, r1_v;
    logic [7:0]  r1_s;
    logic        r2_rdy, r2_vld, r2_c, r2_v;
    logic [7:0]  r2_s;
    logic        r3_rdy, r3_vld, r3_c, r3_v;
    logic [63:0] r3_s;

    always #5 clk_i = ~clk_i;

    pipelined_adder #(.WIDTH(W), .STAGES(L)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .VALID_i(valid_in), .READY_o(ready_out),
        .A_i(a_in), .B_i(b_in), .C_i(c_in), .SUB_i(sub_in), .VALID_o(valid_out),
        .READY_i(ready_in), .S_o(s_out), .C_o(c_out), .V_o(v_out)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(1)) u_w8s1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .VALID_i(sw_valid), .READY_o(r1_rdy),
        .A_i(sw_a[7:0]), .B_i(sw_b[7:0]), .C_i(sw_c), .SUB_i(sw_sub), .VALID_o(r1_vld),
        .READY_i(sw_ready), .S_o(r1_s), .C_o(r1_c), .V_o(r1_v)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(8)) u_w8s8 (
        .clk_i(clk_i), .rst_ni(rst_ni), .VALID_i(sw_valid), .READY_o(r2_rdy),
        .A_i(sw_a[7:0]), .B_i(sw_b[7:0]), .C_i(sw_c), .SUB_i(sw_sub), .VALID_o(r2_vld),
        .READY_i(sw_ready), .S_o(r2_s), .C_o(r2_c), .V_o(r2_v)
    );

    pipelined_adder #(.WIDTH(64), .STAGES(4)) u_w64s4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .VALID_i(sw_valid), .READY_o(r3_rdy),
        .A_i(sw_a), .B_i(sw_b), .C_i(sw_c), .SUB_i(sw_sub), .VALID_o(r3_vld),
        .READY_i(sw_ready), .S_o(r3_s), .C_o(r3_c), .V_o(r3_v)
    );

    // Plain integer arithmetic: unsigned result gives S and carry/no-borrow, signed result
    // gives overflow when it leaves the representable range.
    function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub, input int w);
        logic signed [67:0] m, ua, ub, sa, sb, ci, ur, sr;
        res_t r;
        m  = 68'sd1 <<< w;
        ua = '0;
        ua[63:0] = a;
        ua = ua & (m - 68'sd1);
        ub = '0;
        ub[63:0] = b;
        ub = ub & (m - 68'sd1);
        sa = ua[w-1] ? ua - m : ua;
        sb = ub[w-1] ? ub - m : ub;
        ci = '0;
        ci[0] = cin;
        ur = sub ? ua - ub - ci : ua + ub + ci;
        sr = sub ? sa - sb - ci : sa + sb + ci;
        r.s = 64'(ur & (m - 68'sd1));
        r.c = sub ? (ur >= 0) : (ur >= m);
        r.v = (sr >= (m >>> 1)) || (sr < -(m >>> 1));
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic apply_vec(input vec_t t, input int idx);
        int    lat;
        string tag;
        tag      = $sformatf("vec%0d", idx);
        a_in     = t.a;
        b_in     = t.b;
        c_in     = t.ci;
        sub_in   = t.sub;
        valid_in = 1'b1;
        ready_in = 1'b1;
        @(posedge clk_i); #1;
        valid_in = 1'b0;
        a_in     = '1;
        b_in     = '1;
        lat      = 1;
        while (!valid_out && lat < 12) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(L));
        check({tag, "_s"}, 64'(s_out), 64'(t.s));
        check({tag, "_c"}, 64'(c_out), 64'(t.co));
        check({tag, "_v"}, 64'(v_out), 64'(t.ov));
        @(posedge clk_i); #1;
        check({tag, "_pulse"}, 64'(valid_out), 64'(0));
    endtask

    task automatic run_stream(input string tag, input int n_ops, input int vld_pct,
                              input int rdy_pct, input bit chk_lat);
        res_t        exp_q[$];
        int          acc_q[$];
        res_t        e;
        int          acc, sent, got, cyc, guard, extra;
        bit          have_op, stall_prev;
        logic [31:0] s_prev;
        logic        c_prev, v_prev;
        sent = 0; got = 0; cyc = 0; guard = 0; have_op = 0; stall_prev = 0;
        s_prev = '0; c_prev = 0; v_prev = 0;
        while (got < n_ops && guard < n_ops * 10 + 100) begin
            guard++;
            if (!have_op && sent < n_ops && $urandom_range(99) < vld_pct) begin
                a_in    = ($urandom_range(7) == 0) ? '1 : $urandom;
                b_in    = ($urandom_range(7) == 0) ? '0 : $urandom;
                c_in    = 1'($urandom_range(1));
                sub_in  = 1'($urandom_range(1));
                have_op = 1;
            end
            valid_in = have_op;
            ready_in = ($urandom_range(99) < rdy_pct);
            #1;
            if (stall_prev) begin
                check({tag, "_hold_valid"}, 64'(valid_out), 64'(1));
                check({tag, "_hold_data"}, {s_out, c_out, v_out}, {s_prev, c_prev, v_prev});
            end
            check({tag, "_ready"}, 64'(ready_out), 64'(!valid_out || ready_in));
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_unexpected"}, 64'(1), 64'(0));
                end else begin
                    e   = exp_q.pop_front();
                    acc = acc_q.pop_front();
                    check({tag, "_result"}, {s_out, c_out, v_out}, {e.s[31:0], e.c, e.v});
                    if (chk_lat) check({tag, "_latency"}, 64'(cyc - acc), 64'(L));
                end
                got++;
            end
            stall_prev = valid_out && !ready_in;
            s_prev = s_out;
            c_prev = c_out;
            v_prev = v_out;
            if (valid_in && ready_out) begin
                exp_q.push_back(model(64'(a_in), 64'(b_in), c_in, sub_in, 32));
                acc_q.push_back(cyc);
                sent++;
                have_op = 0;
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        extra = 0;
        repeat (8) begin
            #1;
            if (valid_out) extra++;
            @(posedge clk_i); #1;
        end
        check({tag, "_count"}, 64'(got), 64'(n_ops));
        check({tag, "_extra"}, 64'(extra), 64'(0));
    endtask

    task automatic check_sw(input string name, input int w, input int lat, input int p,
                            input logic vld, input logic [63:0] s, input logic c,
                            input logic v);
        int   q;
        res_t e;
        logic exp_v;
        q     = p - lat;
        exp_v = (q >= 0) && (q < SwN);
        check({name, "_valid"}, 64'(vld), 64'(exp_v));
        if (exp_v) begin
            e = model(sw_ah[q], sw_bh[q], sw_ch[q], sw_subh[q], w);
            check({name, "_result"}, {s, c, v}, {e.s, e.c, e.v});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[9];
        int   seen, lat;
        res_t e;
        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[7] = '{32'h00FF_FF00, 32'h0000_0100, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
        vecs[8] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

        rst_ni = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        a_in = '0; b_in = '0; c_in = 1'b0; sub_in = 1'b0;
        sw_valid = 1'b0; sw_ready = 1'b1; sw_a = '0; sw_b = '0; sw_c = 1'b0; sw_sub = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_valid", 64'(valid_out), 64'(0));
        check("rst_outputs", {s_out, c_out, v_out}, 64'(0));
        #2 rst_ni = 1'b1;
        #1 check("rst_ready", 64'(ready_out), 64'(1));
        @(posedge clk_i); #1;

        for (int i = 0; i < 9; i++) apply_vec(vecs[i], i);

        run_stream("stream", 1000, 100, 100, 1'b1);
        run_stream("bp", 300, 70, 50, 1'b0);

        // Reset while three ops are in flight and the first one is at the output.
        valid_in = 1'b1;
        ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in = $urandom; b_in = $urandom; c_in = 1'b0; sub_in = 1'b0;
            @(posedge clk_i); #1;
        end
        valid_in = 1'b0;
        @(posedge clk_i); #1;
        check("mid_valid_before", 64'(valid_out), 64'(1));
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst_valid", 64'(valid_out), 64'(0));
        check("mid_rst_s", 64'(s_out), 64'(0));
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        seen = 0;
        repeat (8) begin
            if (valid_out) seen++;
            @(posedge clk_i); #1;
        end
        check("mid_ghost", 64'(seen), 64'(0));
        a_in = 32'h1234_5678; b_in = 32'h1111_1111; c_in = 1'b1; sub_in = 1'b0;
        e = model(64'(a_in), 64'(b_in), c_in, sub_in, 32);
        valid_in = 1'b1;
        @(posedge clk_i); #1;
        valid_in = 1'b0;
        lat = 1;
        while (!valid_out && lat < 12) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check("mid_latency", 64'(lat), 64'(L));
        check("mid_result", {s_out, c_out, v_out}, {e.s[31:0], e.c, e.v});
        seen = 0;
        repeat (8) begin
            @(posedge clk_i); #1;
            if (valid_out) seen++;
        end
        check("mid_after", 64'(seen), 64'(0));

        for (int p = 0; p < SwN + 10; p++) begin
            if (p < SwN) begin
                sw_a   = (p == 0) ? '1 : {$urandom, $urandom};
                sw_b   = (p == 0) ? '1 : {$urandom, $urandom};
                sw_c   = (p == 0) ? 1'b1 : 1'($urandom_range(1));
                sw_sub = (p == 0) ? 1'b0 : 1'($urandom_range(1));
                sw_ah[p] = sw_a; sw_bh[p] = sw_b; sw_ch[p] = sw_c; sw_subh[p] = sw_sub;
                sw_valid = 1'b1;
            end else begin
                sw_valid = 1'b0;
            end
            #1;
            if (p == SwN) check("sw_ready", {r1_rdy, r2_rdy, r3_rdy}, 64'h7);
            check_sw("sw8x1", 8, 1, p, r1_vld, 64'(r1_s), r1_c, r1_v);
            check_sw("sw8x8", 8, 8, p, r2_vld, 64'(r2_s), r2_c, r2_v);
            check_sw("sw64x4", 64, 4, p, r3_vld, r3_s, r3_c, r3_v);
            @(posedge clk_i); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
